// File: rtl/counter_mod100_if.sv
// counter_mod100_if: carries the two redundant count outputs of counter_mod100
interface counter_mod100_if #(
  parameter int CNT_W = 7
);
  logic [CNT_W-1:0] o_cnt;
  logic [CNT_W-1:0] o_cnt_always;
  modport master (output o_cnt, output o_cnt_always);
  modport slave (input o_cnt, input o_cnt_always);
endinterface

// File: rtl/counter_mod100.sv
// counter_mod100: free-running modulo-CNT_MAX counter built twice for cross-checking
module counter_mod100 #(
  parameter int CNT_MAX = 100,
  parameter int CNT_W = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  counter_mod100_if.master  cnt_if
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CNT_MAX - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_always_q;
  // >= rather than == so an out-of-range value recovers on the next edge
  assign cnt_d = (cnt_q >= LAST) ? '0 : cnt_q + CNT_W'(1);
  always_ff @(posedge clk or posedge reset_n)
    if (reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  always_ff @(posedge clk or posedge reset_n)
    if (reset_n) cnt_always_q <= '0;
    else cnt_always_q <= (cnt_always_q >= LAST) ? '0 : cnt_always_q + CNT_W'(1);
  assign cnt_if.o_cnt = cnt_q;
  assign cnt_if.o_cnt_always = cnt_always_q;
endmodule

// File: tb/tb_counter_mod100.sv
// tb_counter_mod100: directed checks of the mod-100 counter and a mod-10 variant
module tb_counter_mod100;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  int exp100, exp10, max100, max10, k;
  counter_mod100_if #(.CNT_W(7)) if100();
  counter_mod100_if #(.CNT_W(4)) if10();
  counter_mod100 #(.CNT_MAX(100), .CNT_W(7)) dut (.clk(clk), .reset_n(reset_n), .cnt_if(if100.master));
  counter_mod100 #(.CNT_MAX(10), .CNT_W(4)) dut10 (.clk(clk), .reset_n(reset_n), .cnt_if(if10.master));
  always #5 clk = ~clk;
  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_all(input string tag, input int e100, input int e10);
    check_eq({tag, " o_cnt"}, int'(if100.o_cnt), e100);
    check_eq({tag, " o_cnt_always"}, int'(if100.o_cnt_always), e100);
    check_eq({tag, " mod10 o_cnt"}, int'(if10.o_cnt), e10);
    check_eq({tag, " mod10 o_cnt_always"}, int'(if10.o_cnt_always), e10);
  endtask
  initial begin
    #1 check_all("async reset at t0", 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_all("power-up reset", 0, 0);
    end
    reset_n = 1'b0;
    max100 = 0;
    max10 = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      check_all("release/wrap", n % 100, n % 10);
      if (int'(if100.o_cnt) > max100) max100 = int'(if100.o_cnt);
      if (int'(if10.o_cnt) > max10) max10 = int'(if10.o_cnt);
    end
    check_eq("max value mod100", max100, 99);
    check_eq("max value mod10", max10, 9);
    for (int n = 1; n <= 57; n++) @(negedge clk);
    check_all("count 57", 57, 7);
    #2 reset_n = 1'b1;
    #1 check_all("async mid-count reset", 0, 0);
    repeat (2) @(negedge clk);
    check_all("held in reset", 0, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check_all("restart after reset", 1, 1);
    repeat (3) @(negedge clk);
    check_all("count 4", 4, 4);
    @(posedge clk);
    reset_n = 1'b1;
    #1 check_all("reset coincident with edge", 0, 0);
    @(negedge clk);
    reset_n = 1'b0;
    exp100 = 0;
    exp10 = 0;
    k = $urandom_range(20, 150);
    for (int i = 0; i < 200; i++) begin
      if (i == k) begin
        #2 reset_n = 1'b1;
        #1 check_all("random pulse async clear", 0, 0);
      end
      if (i == k + 3) #2 reset_n = 1'b0;
      @(posedge clk);
      #1;
      exp100 = reset_n ? 0 : (exp100 == 99 ? 0 : exp100 + 1);
      exp10 = reset_n ? 0 : (exp10 == 9 ? 0 : exp10 + 1);
      check_eq("equivalence", int'(if100.o_cnt), int'(if100.o_cnt_always));
      check_all("random run", exp100, exp10);
      @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_mod100.md
Name: counter_mod100

Overview:
Free-running modulo-100 counter, 0..99 then wrap to 0, with two independently implemented but cycle-identical outputs.
- o_cnt: state register plus a separate combinational next-state path.
- o_cnt_always: self-contained single sequential process.

Used as a timebase/divider building block. The dual implementation is a built-in cross-check: the two outputs must never differ.

Parameters:
- CNT_MAX, 100, modulus; count range 0..CNT_MAX-1.
- CNT_W, 7, output width; must satisfy 2^CNT_W >= CNT_MAX.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset_n  input  1  reset, asynchronous and active-high: reset_n=1 asserts reset, reset_n=0 is normal operation.
- o_cnt  output  CNT_W  count from the register + combinational next-state implementation.
- o_cnt_always  output  CNT_W  count from the single-process implementation.

Behaviour:
- Reset:
  - Asynchronous; reset_n=1 forces o_cnt=0 and o_cnt_always=0 immediately, with no clock edge required.
  - Both outputs hold 0 for as long as reset_n=1, regardless of clk.
- Counting:
  - Counting runs only while reset_n=0.
  - Each rising clk edge: next = (cnt == CNT_MAX-1) ? 0 : cnt+1.
  - No enable input; counting is unconditional.
- Release timing:
  - First rising edge after reset_n falls yields 1.
  - The N-th edge yields N mod CNT_MAX.
- Wrap:
  - 99 -> 0 on the 100th edge after release.
  - Full period is exactly CNT_MAX cycles.
  - Values 100..127 are never produced.
- o_cnt implementation:
  - Next-state value formed combinationally (continuous assignment / comparator + incrementer).
  - The register only samples it.
- o_cnt_always implementation:
  - Compare, increment and wrap all inside one clocked process with async reset.
- Equivalence: o_cnt == o_cnt_always at every instant, including during and immediately after reset.
- Latency: both outputs are registered, 1-cycle update; no combinational path from inputs to outputs other than async reset.
- Mid-operation reset: asserting reset at any count (e.g. 57) clears both outputs to 0 at once. After deassertion, counting restarts from 0 (first edge -> 1).
- Reset and clock edge coincident: reset wins; output is 0.
- Illegal state recovery: if a register holds a value >= CNT_MAX, the next edge loads 0, using a >= compare rather than an equality-only compare.

Test Plan:
- Power-up: reset_n=1 for 10 cycles -> o_cnt=o_cnt_always=0 throughout.
- Release: reset_n 1->0, run 5 edges -> outputs 1,2,3,4,5 on successive edges.
- Wrap: run 200 edges after release -> edge 99 gives 99, edge 100 gives 0, edge 199 gives 99, edge 200 gives 0; max observed value 99.
- Async mid-count reset: at count 57, assert reset_n=1 between clock edges -> both outputs 0 before the next edge; release -> next edge gives 1.
- Equivalence: 2000 ns run at 10 ns clock with a random reset pulse -> o_cnt == o_cnt_always checked every cycle, zero mismatches.
- Parameter check: CNT_MAX=10, CNT_W=4 -> sequence 0..9,0 and period 10 cycles.
